// File: rtl/game_pkg.sv
// Shared definitions for the player-sample receiver and the game FSMs that consume its samples.
package game_pkg;

    localparam int DATA_W     = 12;
    localparam int NUM_CH     = 2;
    localparam int FRAME_BITS = DATA_W * NUM_CH;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT,
        LATCH
    } rx_state_t;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one extra history flop for edge pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/adc_spi_rx.sv
// SPI mode-0 receiver: deserializes one 24-bit frame into two player samples, updated atomically.
module adc_spi_rx
    import game_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              sdi,
    output logic [DATA_W-1:0] p1data,
    output logic [DATA_W-1:0] p2data,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = DATA_W * NUM_CH;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_W + 1);

    logic sck_unused_q, sck_rise, sck_unused_fall;
    logic cs_q, cs_rise, cs_unused_fall;
    logic sdi_q, sdi_unused_rise, sdi_unused_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk  (clk),
        .reset(reset),
        .d    (sck),
        .q    (sck_unused_q),
        .rise (sck_rise),
        .fall (sck_unused_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .reset(reset),
        .d    (cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_unused_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk  (clk),
        .reset(reset),
        .d    (sdi),
        .q    (sdi_q),
        .rise (sdi_unused_rise),
        .fall (sdi_unused_fall)
    );

    rx_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-1:0]   shreg_q;
    logic [DATA_W-1:0]    p1data_q, p2data_q;
    logic                 valid_q, frame_err_q, busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            p1data_q    <= '0;
            p2data_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                WAIT_IDLE: begin
                    if (cs_q) state_q <= IDLE;
                end
                IDLE: begin
                    // Level test so a CS fall that landed during LATCH is still honoured here.
                    if (!cs_q) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        if (cnt_q < CNT_FULL) begin
                            shreg_q <= {shreg_q[FRAME_W-2:0], sdi_q};
                            cnt_q   <= cnt_q + 1'b1;
                        end else begin
                            cnt_q   <= CNT_OVR;
                        end
                    end
                    if (cs_rise) begin
                        state_q <= LATCH;
                        busy_q  <= 1'b0;
                    end
                end
                LATCH: begin
                    if (cnt_q == CNT_FULL) begin
                        p1data_q <= shreg_q[FRAME_W-1 -: DATA_W];
                        p2data_q <= shreg_q[FRAME_W-DATA_W-1 -: DATA_W];
                        valid_q  <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign p1data    = p1data_q;
    assign p2data    = p2data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
